// File: rtl/sad_disparity_engine_pkg.sv
// Shared definitions for the SAD disparity engine: state encoding and width helpers.
package disparity_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SEARCH, OUTPUT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Bits needed to index 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int block_size(input int h);
        return 2 * h + 1;
    endfunction

    function automatic int sad_width(input int pix_w, input int h);
        return pix_w + clog2(block_size(h) * block_size(h));
    endfunction

    localparam int BLOCK_SIZE = block_size(3);
    localparam int SAD_W      = sad_width(8, 3);

endpackage

// File: rtl/sad_disparity_engine_sad_window_accum.sv
// Walks a clipped SAD window one cell per cycle, issuing frame addresses and
// accumulating |left - right| once the 1-cycle RAM reads return.
module sad_window_accum
    import disparity_pkg::*;
#(
    parameter int WIDTH      = 46,
    parameter int HEIGHT     = 30,
    parameter int PIX_W      = 8,
    parameter int HALF_BLOCK = 3,
    parameter int MAX_DISP   = 46,
    localparam int XW = width_of(WIDTH),
    localparam int YW = width_of(HEIGHT),
    localparam int DW = width_of(MAX_DISP + 1),
    localparam int AW = width_of(WIDTH * HEIGHT),
    localparam int SW = sad_width(PIX_W, HALF_BLOCK)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [YW-1:0]    r_lo,
    input  logic [YW-1:0]    r_hi,
    input  logic [XW-1:0]    c_lo,
    input  logic [XW-1:0]    c_hi,
    input  logic [DW-1:0]    d,
    output logic [AW-1:0]    left_addr,
    output logic [AW-1:0]    right_addr,
    input  logic [PIX_W-1:0] left_rd,
    input  logic [PIX_W-1:0] right_rd,
    output logic [SW-1:0]    sad,
    output logic             done
);

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic          busy;
    logic [YW-1:0] r_p0, r_hi_q;
    logic [XW-1:0] c_p0, c_lo_q, c_hi_q;
    logic [DW-1:0] d_q;
    logic          vld_p1, last_p1;

    // Stage p0: address issue
    assign left_addr  = AW'(int'(r_p0) * WIDTH + int'(c_p0));
    assign right_addr = AW'(int'(r_p0) * WIDTH + int'(c_p0) + int'(d_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            r_p0    <= '0;
            c_p0    <= '0;
            r_hi_q  <= '0;
            c_lo_q  <= '0;
            c_hi_q  <= '0;
            d_q     <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            done    <= 1'b0;
        end else begin
            vld_p1  <= busy;
            last_p1 <= busy && (r_p0 == r_hi_q) && (c_p0 == c_hi_q);
            done    <= vld_p1 && last_p1;
            if (start) begin
                busy   <= 1'b1;
                r_p0   <= r_lo;
                c_p0   <= c_lo;
                r_hi_q <= r_hi;
                c_lo_q <= c_lo;
                c_hi_q <= c_hi;
                d_q    <= d;
            end else if (busy) begin
                if (c_p0 == c_hi_q) begin
                    c_p0 <= c_lo_q;
                    if (r_p0 == r_hi_q) busy <= 1'b0;
                    else                r_p0 <= r_p0 + 1'b1;
                end else begin
                    c_p0 <= c_p0 + 1'b1;
                end
            end
        end
    end

    // Stage p1: read data returned, accumulate
    always_ff @(posedge clk) begin
        if (start)       sad <= '0;
        else if (vld_p1) sad <= sad + SW'(absdiff(left_rd, right_rd));
    end

endmodule

// File: rtl/sad_disparity_engine.sv
// Stereo disparity engine: loads left/right frames into local RAM, then block-matches
// every left pixel against right candidates 0..MAX_DISP and streams the winners.
module sad_disparity_engine
    import disparity_pkg::*;
#(
    parameter int WIDTH      = 46,
    parameter int HEIGHT     = 30,
    parameter int PIX_W      = 8,
    parameter int HALF_BLOCK = 3,
    parameter int MAX_DISP   = 46,
    parameter int DISP_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [DISP_W-1:0] disp_data,
    output logic              disp_last,
    output logic              image_sel,
    output logic              idle
);

    localparam int XW = width_of(WIDTH);
    localparam int YW = width_of(HEIGHT);
    localparam int DW = width_of(MAX_DISP + 1);
    localparam int AW = width_of(WIDTH * HEIGHT);
    localparam int SW = sad_width(PIX_W, HALF_BLOCK);
    localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] d;
    logic          kick;
    logic [SW-1:0] best_sad, best_sad_next, acc_sad;
    logic [DW-1:0] best_d, best_d_next;
    logic          acc_done, better, last_d, last_pix, xfer, load_done;
    logic [YW-1:0] r_lo_c, r_hi_c;
    logic [XW-1:0] c_lo_c, c_hi_c;
    logic [AW-1:0] wr_addr, acc_left_addr, acc_right_addr, left_addr, right_addr;
    logic [PIX_W-1:0] left_rd, right_rd;
    logic [PIX_W-1:0] left_mem  [WIDTH*HEIGHT];
    logic [PIX_W-1:0] right_mem [WIDTH*HEIGHT];

    always_comb begin
        int lim;
        r_lo_c   = YW'((int'(y) >= HALF_BLOCK) ? int'(y) - HALF_BLOCK : 0);
        r_hi_c   = YW'((int'(y) + HALF_BLOCK > HEIGHT - 1) ? HEIGHT - 1 : int'(y) + HALF_BLOCK);
        c_lo_c   = XW'((int'(x) >= HALF_BLOCK) ? int'(x) - HALF_BLOCK : 0);
        c_hi_c   = XW'((int'(x) + HALF_BLOCK > WIDTH - 1 - int'(d)) ?
                       WIDTH - 1 - int'(d) : int'(x) + HALF_BLOCK);
        // Candidates stop at MAX_DISP or where column x+d would leave the frame.
        lim      = (MAX_DISP < WIDTH - 1 - int'(x)) ? MAX_DISP : WIDTH - 1 - int'(x);
        last_d   = int'(d) >= lim;
        better   = acc_sad < best_sad;
        best_sad_next = better ? acc_sad : best_sad;
        best_d_next   = better ? d : best_d;
        last_pix  = (x == XMAX) && (y == YMAX);
        xfer      = (state == LOAD) && in_valid && in_ready;
        load_done = xfer && image_sel && last_pix;
        wr_addr   = AW'(int'(y) * WIDTH + int'(x));
        left_addr  = (state == LOAD) ? wr_addr : acc_left_addr;
        right_addr = (state == LOAD) ? wr_addr : acc_right_addr;
    end

    always_ff @(posedge clk) begin
        if (xfer && !image_sel) left_mem[left_addr] <= in_data;
        left_rd <= left_mem[left_addr];
    end

    always_ff @(posedge clk) begin
        if (xfer && image_sel) right_mem[right_addr] <= in_data;
        right_rd <= right_mem[right_addr];
    end

    sad_window_accum #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .PIX_W      (PIX_W),
        .HALF_BLOCK (HALF_BLOCK),
        .MAX_DISP   (MAX_DISP)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .start      (kick),
        .r_lo       (r_lo_c),
        .r_hi       (r_hi_c),
        .c_lo       (c_lo_c),
        .c_hi       (c_hi_c),
        .d          (d),
        .left_addr  (acc_left_addr),
        .right_addr (acc_right_addr),
        .left_rd    (left_rd),
        .right_rd   (right_rd),
        .sad        (acc_sad),
        .done       (acc_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            disp_last  <= 1'b0;
            image_sel  <= 1'b0;
            idle       <= 1'b1;
            x          <= '0;
            y          <= '0;
            d          <= '0;
            kick       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        idle      <= 1'b0;
                        image_sel <= 1'b0;
                        x         <= '0;
                        y         <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (x == XMAX) begin
                            x <= '0;
                            if (y == YMAX) begin
                                y <= '0;
                                if (!image_sel) begin
                                    image_sel <= 1'b1;
                                end else begin
                                    image_sel <= 1'b0;
                                    in_ready  <= 1'b0;
                                    d         <= '0;
                                    kick      <= 1'b1;
                                    state     <= SEARCH;
                                end
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    kick <= 1'b0;
                    if (acc_done) begin
                        if (last_d) begin
                            state      <= OUTPUT;
                            disp_valid <= 1'b1;
                            disp_data  <= DISP_W'(best_d_next);
                            disp_last  <= last_pix;
                        end else begin
                            d    <= d + 1'b1;
                            kick <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        disp_last  <= 1'b0;
                        d          <= '0;
                        if (last_pix) begin
                            state <= IDLE;
                            idle  <= 1'b1;
                            x     <= '0;
                            y     <= '0;
                        end else begin
                            if (x == XMAX) begin
                                x <= '0;
                                y <= y + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                            kick  <= 1'b1;
                            state <= SEARCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_done || (state == OUTPUT && disp_ready)) begin
            best_sad <= '1;
            best_d   <= '0;
        end else if (state == SEARCH && acc_done) begin
            best_sad <= best_sad_next;
            best_d   <= best_d_next;
        end
    end

endmodule

// File: tb/tb_sad_disparity_engine.sv
// Scoreboard bench for sad_disparity_engine on an 8x4 frame, 3x3 window, disparities 0..3.
module tb_sad_disparity_engine;

    localparam int W = 8;
    localparam int H = 4;
    localparam int HB = 1;
    localparam int MD = 3;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_ready, disp_valid, disp_ready, disp_last;
    logic       image_sel, idle;
    logic [7:0] in_data;
    logic [1:0] disp_data;

    typedef struct {
        logic [1:0] disp;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    int         lf[NPIX];
    int         rf[NPIX];
    logic [1:0] got_data[64];
    logic       got_last[64];
    logic       sel_log[2*NPIX];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sad_disparity_engine #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(8), .HALF_BLOCK(HB), .MAX_DISP(MD), .DISP_W(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_data(disp_data), .disp_last(disp_last), .image_sel(image_sel), .idle(idle)
    );

    // Straightforward reference block matcher.
    function automatic int model_disp(input int x, input int y);
        int best, bd, dmax, s, a, b;
        best = 32'h7fffffff;
        bd   = 0;
        dmax = (MD < W - 1 - x) ? MD : W - 1 - x;
        for (int dd = 0; dd <= dmax; dd++) begin
            s = 0;
            for (int r = (y - HB < 0 ? 0 : y - HB); r <= (y + HB > H - 1 ? H - 1 : y + HB); r++)
                for (int c = (x - HB < 0 ? 0 : x - HB); c <= (x + HB > W - 1 - dd ? W - 1 - dd : x + HB); c++) begin
                    a = lf[r*W+c];
                    b = rf[r*W+c+dd];
                    s += (a > b) ? a - b : b - a;
                end
            if (s < best) begin
                best = s;
                bd   = dd;
            end
        end
        return bd;
    endfunction

    task automatic push_expected();
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            e.disp = 2'(model_disp(i % W, i / W));
            e.last = (i == NPIX - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_frames(input bit gapped, input bit spam_start, output bit to);
        int idx, cyc;
        idx = 0;
        cyc = 0;
        to  = 1'b0;
        while (idx < 2 * NPIX) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                to = 1'b1;
                break;
            end
            start = spam_start && (cyc % 5 == 0);
            if (!gapped || cyc % 3 == 0) begin
                in_valid = 1'b1;
                in_data  = 8'(idx < NPIX ? lf[idx] : rf[idx-NPIX]);
                if (in_ready) begin
                    sel_log[idx] = image_sel;
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        push_expected();
    endtask

    task automatic collect(input int max_words, input int base, output int n, output bit to);
        int cyc;
        n   = 0;
        cyc = 0;
        to  = 1'b0;
        disp_ready = 1'b1;
        while (n < max_words) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                to = 1'b1;
                break;
            end
            if (disp_valid && disp_ready) begin
                got_data[base+n] = disp_data;
                got_last[base+n] = disp_last;
                n++;
            end
        end
    endtask

    task automatic count_tail(output int extra);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (disp_valid) extra++;
        end
    endtask

    task automatic set_ident();
        for (int i = 0; i < NPIX; i++) begin
            lf[i] = ((i % W) * 17 + (i / W) * 5) & 255;
            rf[i] = lf[i];
        end
    endtask

    task automatic set_shift();
        for (int i = 0; i < NPIX; i++) lf[i] = (i * 7) & 255;
        for (int i = 0; i < NPIX; i++)
            rf[i] = (i % W >= 2) ? lf[i-2] : 240 + (i / W) * 2 + (i % W);
    endtask

    task automatic test_reset();
        checks++; if (idle !== 1'b1)       begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
        checks++; if (disp_data !== 2'd0)  begin failures++; $display("FAIL reset_disp_data got=%0d exp=0", disp_data); end
        checks++; if (disp_last !== 1'b0)  begin failures++; $display("FAIL reset_disp_last got=%b exp=0", disp_last); end
        checks++; if (image_sel !== 1'b0)  begin failures++; $display("FAIL reset_image_sel got=%b exp=0", image_sel); end
    endtask

    task automatic test_identical();
        int n, extra;
        bit to;
        exp_t e;
        set_ident();
        do_start();
        load_frames(1'b0, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL ident_load_timeout got=timeout exp=done"); end
        collect(NPIX, 0, n, to);
        checks++; if (n != NPIX) begin failures++; $display("FAIL ident_count got=%0d exp=%0d", n, NPIX); end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_data[i] !== 2'd0) begin failures++; $display("FAIL ident_data[%0d] got=%0d exp=0", i, got_data[i]); end
            checks++; if (got_last[i] !== e.last) begin failures++; $display("FAIL ident_last[%0d] got=%b exp=%b", i, got_last[i], e.last); end
        end
        count_tail(extra);
        checks++; if (extra != 0) begin failures++; $display("FAIL ident_extra got=%0d exp=0", extra); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL ident_idle_after got=%b exp=1", idle); end
    endtask

    task automatic test_shift();
        int n;
        bit to;
        exp_t e;
        set_shift();
        do_start();
        load_frames(1'b0, 1'b0, to);
        checks++; if (to) begin failures++; $display("FAIL shift_load_timeout got=timeout exp=done"); end
        collect(NPIX, 0, n, to);
        checks++; if (n != NPIX) begin failures++; $display("FAIL shift_count got=%0d exp=%0d", n, NPIX); end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_data[i] !== e.disp) begin failures++; $display("FAIL shift_data[%0d] got=%0d exp=%0d", i, got_data[i], e.disp); end
            if (i % W <= 5) begin
                checks++; if (got_data[i] !== 2'd2) begin failures++; $display("FAIL shift_d2[%0d] got=%0d exp=2", i, got_data[i]); end
            end
            if (i % W == 7) begin
                checks++; if (got_data[i] !== 2'd0) begin failures++; $display("FAIL shift_edge[%0d] got=%0d exp=0", i, got_data[i]); end
            end
        end
    endtask

    task automatic test_uniform();
        int n;
        bit to;
        for (int i = 0; i < NPIX; i++) begin
            lf[i] = 8'h40;
            rf[i] = 8'h40;
        end
        do_start();
        load_frames(1'b0, 1'b0, to);
        collect(NPIX, 0, n, to);
        checks++; if (n != NPIX) begin failures++; $display("FAIL uniform_count got=%0d exp=%0d", n, NPIX); end
        for (int i = 0; i < n; i++) begin
            void'(exp_q.pop_front());
            checks++; if (got_data[i] !== 2'd0) begin failures++; $display("FAIL uniform_data[%0d] got=%0d exp=0", i, got_data[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n, cyc, extra;
        bit to;
        logic [1:0] first;
        exp_t e;
        set_shift();
        do_start();
        disp_ready = 1'b0;
        load_frames(1'b0, 1'b0, to);
        cyc = 0;
        while (!disp_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (!disp_valid) begin failures++; $display("FAIL bp_first_timeout got=%b exp=1", disp_valid); end
        first = disp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (disp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, disp_valid); end
            checks++; if (disp_data !== first) begin failures++; $display("FAIL bp_hold_data[%0d] got=%0d exp=%0d", i, disp_data, first); end
        end
        got_data[0] = disp_data;
        got_last[0] = disp_last;
        disp_ready  = 1'b1;
        collect(NPIX - 1, 1, n, to);
        n++;
        count_tail(extra);
        checks++; if (n + extra != NPIX) begin failures++; $display("FAIL bp_total got=%0d exp=%0d", n + extra, NPIX); end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_data[i] !== e.disp) begin failures++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_data[i], e.disp); end
            checks++; if (got_last[i] !== e.last) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_last[i], e.last); end
        end
    endtask

    task automatic test_reset_mid_search();
        int n, extra;
        bit to;
        exp_t e;
        set_shift();
        do_start();
        load_frames(1'b0, 1'b0, to);
        disp_ready = 1'b1;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (idle !== 1'b1)       begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
        checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", disp_valid); end
        checks++; if (in_ready !== 1'b0)   begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        count_tail(extra);
        checks++; if (extra != 0) begin failures++; $display("FAIL midrst_no_output got=%0d exp=0", extra); end
        set_ident();
        do_start();
        load_frames(1'b0, 1'b0, to);
        collect(NPIX, 0, n, to);
        checks++; if (n != NPIX) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", n, NPIX); end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_data[i] !== e.disp) begin failures++; $display("FAIL midrst_data[%0d] got=%0d exp=%0d", i, got_data[i], e.disp); end
        end
    endtask

    task automatic test_gapped_load();
        int n;
        bit to;
        exp_t e;
        set_ident();
        do_start();
        load_frames(1'b1, 1'b1, to);
        checks++; if (to) begin failures++; $display("FAIL gap_load_timeout got=timeout exp=done"); end
        for (int i = 0; i < 2 * NPIX; i++) begin
            checks++;
            if (sel_log[i] !== (i >= NPIX)) begin
                failures++;
                $display("FAIL gap_image_sel[%0d] got=%b exp=%b", i, sel_log[i], i >= NPIX);
            end
        end
        collect(NPIX, 0, n, to);
        checks++; if (n != NPIX) begin failures++; $display("FAIL gap_count got=%0d exp=%0d", n, NPIX); end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++; if (got_data[i] !== 2'd0) begin failures++; $display("FAIL gap_data[%0d] got=%0d exp=0", i, got_data[i]); end
            checks++; if (got_last[i] !== e.last) begin failures++; $display("FAIL gap_last[%0d] got=%b exp=%b", i, got_last[i], e.last); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        disp_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_identical();
        test_shift();
        test_uniform();
        test_backpressure();
        test_reset_mid_search();
        test_gapped_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_disparity_engine.md
Name: sad_disparity_engine

Overview:
- Parametrised successor to the fixed-size disparity FSM.
- Buffers one left and one right grey frame from the FIFO side via a valid/ready stream.
- For every left pixel, computes a SAD block match over a clipped window against right-frame candidates at column offsets 0..MAX_DISP. Emits the winning disparity per pixel, row-major, on a valid/ready output stream.
- Sits between the frame buffer/FIFO reader and the VGA/display writer.

Parameters:
- WIDTH, 46: frame width in pixels (≥2).
- HEIGHT, 30: frame height in pixels (≥1).
- PIX_W, 8: pixel bit width.
- HALF_BLOCK, 3: window half size; block edge = 2*HALF_BLOCK+1.
- MAX_DISP, 46: largest disparity searched (≥0).
- DISP_W, 6: disparity output width, ≥ clog2(MAX_DISP+1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new load/compute sequence when idle.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  engine accepts a pixel.
- in_data  in  PIX_W  pixel; left frame row-major first, then right frame row-major.
- disp_valid  out  1  disparity word valid.
- disp_ready  in  1  downstream accepts the word.
- disp_data  out  DISP_W  best disparity for the current pixel.
- disp_last  out  1  high with the final pixel (x=WIDTH-1, y=HEIGHT-1).
- image_sel  out  1  0 while loading left, 1 while loading right.
- idle  out  1  high in IDLE.

Behaviour:
- Reset: state=IDLE; in_ready=0, disp_valid=0, disp_data=0, disp_last=0, image_sel=0, idle=1. All counters are zeroed. Frame memory contents are don't-care.
- Reset asserted in any state aborts the sequence within one cycle: state returns to IDLE, any partial output is dropped, and no further disp_valid is issued.
- State IDLE: start=1 → LOAD. start is ignored in all other states.
- State LOAD:
  - in_ready=1.
  - Each in_valid&in_ready transfer writes left[y][x] (image_sel=0) or right[y][x] (image_sel=1); x increments, wrapping at WIDTH-1 into y.
  - After WIDTH*HEIGHT left pixels, image_sel→1 and x,y→0.
  - After WIDTH*HEIGHT right pixels, go to SEARCH with x=y=0, d=0, best_sad=all ones, best_d=0.
- State SEARCH (one candidate d for pixel (x,y)):
  - Window rows run from max(0,y-H) to min(HEIGHT-1,y+H).
  - Window columns run from max(0,x-H) to min(WIDTH-1-d, x+H), where H=HALF_BLOCK.
  - One cell per cycle: sad += |left[r][c] - right[r][c+d]|. Absolute value is computed unsigned, as the larger operand minus the smaller.
  - SAD accumulator width = PIX_W + clog2((2H+1)^2); it cannot overflow.
  - Memory reads have 1-cycle latency. A candidate therefore takes N_cells+1 cycles, then 1 compare cycle.
- Compare rule:
  - If sad < best_sad (strict), update best_sad and best_d.
  - Ties keep the smaller d.
- Candidate range:
  - d runs 0..min(MAX_DISP, WIDTH-1-x); d never references a column ≥ WIDTH.
  - When the last d for a pixel is done → OUTPUT.
- State OUTPUT:
  - disp_valid=1, disp_data=best_d, disp_last set on the last pixel.
  - Outputs hold stable while disp_ready=0.
  - On disp_valid&disp_ready: advance x,y (row-major) and reset d, best_sad, best_d, then → SEARCH. After the last pixel → IDLE.
- in_ready=0 in every state except LOAD.

Decomposition:
- Shared package disparity_pkg: the state encoding (IDLE, LOAD, SEARCH, OUTPUT), a clog2 function, and the derived BLOCK_SIZE and SAD_W constants.
- One natural sub-module, sad_window_accum: it takes window bounds and d, sequences r,c, issues the memory addresses, and returns the SAD with a done pulse.
- The frame memories are inferred as two single-port RAMs inside the top module.

Test Plan:
All scenarios use WIDTH=8, HEIGHT=4, HALF_BLOCK=1, MAX_DISP=3, DISP_W=2.
1. Identical frames with a textured pattern (left=right=x*17+y*5) → all 32 outputs are 0; disp_last is high only on the 32nd word; idle returns high afterwards.
2. Right frame equals the left frame shifted by 2 (right[y][x]=left[y][x-2] for x≥2, with unique pixel values) → pixels with x≤5 report 2. Pixels x=6,7 report the best d within their limited range (x=7 → 0).
3. Uniform frames (all pixels 0x40) → every candidate SAD=0; the tie rule yields disparity 0 everywhere.
4. Hold disp_ready=0 for 5 cycles on the first output → disp_valid stays 1 and disp_data is stable. Exactly one word is consumed when ready rises, and the total count stays 32.
5. Assert reset for 1 cycle midway through SEARCH → next cycle idle=1, disp_valid=0, in_ready=0. A new start followed by a full reload gives correct results.
6. Drive in_valid with gaps (1 of every 3 cycles) during LOAD → image_sel flips exactly after pixel 32. start pulses during LOAD are ignored, and the results match scenario 1.
